// File: rtl/mem_io_bridge.sv
// ---------------------------------------------------------------------------
// mem_io_bridge
//
// Memory/I-O bridge for the LC-3 datapath. It sits just below the control
// FSM and owns the MAR and MDR registers. It also turns the FSM's active-low
// Mem_OE / Mem_WE requests into timed SRAM read and write cycles. Address
// IO_ADDR is decoded as memory-mapped I/O:
//   - a read there returns the board switches;
//   - a write there loads the hex display register and never strobes the SRAM.
// Each completed access returns a single-cycle Mem_Ready pulse.
//
// Ports
//   Clk, Reset        : clock (rising edge) and asynchronous active-high reset
//   Bus               : shared datapath bus, source for MAR and (MIO_EN=0) MDR
//   LD_MAR, LD_MDR    : register load enables from the control FSM
//   MIO_EN            : MDR source select (1 = read-capture data, 0 = Bus)
//   Mem_OE, Mem_WE    : active-low read / write requests from the control FSM
//   Switches          : I/O read source
//   SRAM_DQ_in        : data returned by the SRAM
//   MAR, MDR          : architectural address / data registers
//   Mem_Ready         : one-cycle access-complete pulse
//   SRAM_ADDR         : {4'b0, MAR}
//   SRAM_DQ_out/_oe   : write data (MDR) and its pin-driver enable
//   SRAM_*_N          : active-low SRAM strobes
//   HEX_reg           : hex display register
// ---------------------------------------------------------------------------
module mem_io_bridge #(
  parameter int          READ_WAIT   = 2,
  parameter int          WRITE_PULSE = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Bus,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] Switches,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic        Mem_Ready,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [15:0] HEX_reg
);

  // The wait counter holds values 0 .. max(READ_WAIT, WRITE_PULSE)-1.
  localparam int MAX_WAIT = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WRITE_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_DONE  = 3'd2,
    WR_PULSE = 3'd3,
    WR_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [15:0]      r_mar;
  logic [15:0]      r_mdr;
  logic [15:0]      r_hex;
  logic [15:0]      r_rd_capture;
  logic             r_ready;

  logic             w_is_io;
  logic             w_capture;
  logic             w_hex_load;
  logic             w_enter_done;

  assign w_is_io = (r_mar == IO_ADDR);

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_hex_load   = 1'b0;
    w_enter_done = 1'b0;
    case (r_state)
      IDLE: begin
        // A write request takes precedence over a simultaneous read request.
        if (!Mem_WE) begin
          w_state_next = WR_PULSE;
          w_cnt_next   = WR_INIT;
        end else if (!Mem_OE) begin
          w_state_next = RD_WAIT;
          w_cnt_next   = RD_INIT;
        end
      end
      RD_WAIT: begin
        // The FSM withdrawing OE early aborts the read; nothing is captured.
        if (Mem_OE) begin
          w_state_next = IDLE;
        end else if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_enter_done = 1'b1;
          w_state_next = RD_DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      RD_DONE: begin
        if (Mem_OE) w_state_next = IDLE;
      end
      WR_PULSE: begin
        if (r_cnt == '0) begin
          // The HEX load happens only on the edge that leaves WR_PULSE,
          // so each I/O write updates it exactly once.
          w_hex_load   = w_is_io;
          w_enter_done = 1'b1;
          w_state_next = WR_DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      WR_DONE: begin
        if (Mem_WE) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Strobe decode from the registered state. Reset clears the state
  // asynchronously, so the strobes deassert at once.
  always_comb begin
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_UB_N  = 1'b1;
    SRAM_LB_N  = 1'b1;
    SRAM_DQ_oe = 1'b0;
    case (r_state)
      RD_WAIT, RD_DONE: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
      end
      WR_PULSE: begin
        SRAM_CE_N  = 1'b0;
        SRAM_UB_N  = 1'b0;
        SRAM_LB_N  = 1'b0;
        SRAM_DQ_oe = 1'b1;
        SRAM_WE_N  = w_is_io;  // I/O writes never strobe the SRAM
      end
      WR_DONE: begin
        SRAM_CE_N  = 1'b0;
        SRAM_UB_N  = 1'b0;
        SRAM_LB_N  = 1'b0;
        SRAM_DQ_oe = 1'b1;  // hold data past the WE rising edge
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_mar        <= '0;
      r_mdr        <= '0;
      r_hex        <= '0;
      r_rd_capture <= '0;
      r_ready      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // r_ready is high only in the first cycle of RD_DONE / WR_DONE.
      r_ready <= w_enter_done;
      if (LD_MAR) r_mar <= Bus;
      if (LD_MDR) r_mdr <= MIO_EN ? r_rd_capture : Bus;
      if (w_capture) r_rd_capture <= w_is_io ? Switches : SRAM_DQ_in;
      if (w_hex_load) r_hex <= r_mdr;
    end
  end

  assign MAR         = r_mar;
  assign MDR         = r_mdr;
  assign HEX_reg     = r_hex;
  assign Mem_Ready   = r_ready;
  assign SRAM_ADDR   = {4'b0000, r_mar};
  assign SRAM_DQ_out = r_mdr;

endmodule

// File: tb/tb_mem_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_io_bridge
//
// Directed bench for mem_io_bridge with the default parameters
// (READ_WAIT=2, WRITE_PULSE=2, IO_ADDR=16'hFFFF). Inputs change 1 time unit
// after a rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_mem_io_bridge;

  logic        Clk;
  logic        Reset;
  logic [15:0] Bus;
  logic        LD_MAR;
  logic        LD_MDR;
  logic        MIO_EN;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] Switches;
  logic [15:0] SRAM_DQ_in;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic        Mem_Ready;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic [15:0] HEX_reg;

  int checks = 0;
  int errors = 0;

  // {CE_N, OE_N, WE_N, UB_N, LB_N}
  logic [4:0] strobes;
  assign strobes = {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N};

  mem_io_bridge dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Bus        (Bus),
    .LD_MAR     (LD_MAR),
    .LD_MDR     (LD_MDR),
    .MIO_EN     (MIO_EN),
    .Mem_OE     (Mem_OE),
    .Mem_WE     (Mem_WE),
    .Switches   (Switches),
    .SRAM_DQ_in (SRAM_DQ_in),
    .MAR        (MAR),
    .MDR        (MDR),
    .Mem_Ready  (Mem_Ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_oe (SRAM_DQ_oe),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_OE_N  (SRAM_OE_N),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_UB_N  (SRAM_UB_N),
    .SRAM_LB_N  (SRAM_LB_N),
    .HEX_reg    (HEX_reg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset      = 1'b1;
    Bus        = 16'h0000;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    Switches   = 16'h0000;
    SRAM_DQ_in = 16'h0000;
    #2;
    check("rst_mar", MAR, 16'h0000);
    check("rst_mdr", MDR, 16'h0000);
    check("rst_hex", HEX_reg, 16'h0000);
    check("rst_ready", Mem_Ready, 1'b0);
    check("rst_dq_oe", SRAM_DQ_oe, 1'b0);
    check("rst_strobes", strobes, 5'b11111);
    step();
    step();
    Reset = 1'b0;
    step();
    $display("T0 reset checked");

    // 1: MAR load
    Bus = 16'h1234; LD_MAR = 1'b1;
    step();
    LD_MAR = 1'b0;
    check("t1_mar", MAR, 16'h1234);
    check("t1_addr", SRAM_ADDR, 20'h01234);
    check("t1_strobes", strobes, 5'b11111);
    $display("T1 MAR load 1234");

    // 2: SRAM read, READ_WAIT=2
    Bus = 16'h0040; LD_MAR = 1'b1;
    step();
    LD_MAR = 1'b0;
    SRAM_DQ_in = 16'hBEEF;
    Mem_OE = 1'b0;
    step();  // edge N -> RD_WAIT
    check("t2_rw0_strobes", strobes, 5'b00100);
    check("t2_rw0_ready", Mem_Ready, 1'b0);
    step();  // N+1
    check("t2_rw1_oe_n", SRAM_OE_N, 1'b0);
    check("t2_rw1_ready", Mem_Ready, 1'b0);
    step();  // N+2 -> RD_DONE
    check("t2_done_ready", Mem_Ready, 1'b1);
    check("t2_done_oe_n", SRAM_OE_N, 1'b0);
    step();
    check("t2_hold_ready", Mem_Ready, 1'b0);
    check("t2_hold_oe_n", SRAM_OE_N, 1'b0);
    Mem_OE = 1'b1; LD_MDR = 1'b1; MIO_EN = 1'b1;
    step();
    LD_MDR = 1'b0; MIO_EN = 1'b0;
    check("t2_mdr", MDR, 16'hBEEF);
    check("t2_idle_strobes", strobes, 5'b11111);
    $display("T2 SRAM read 0040 -> BEEF");

    // 3: SRAM write, WRITE_PULSE=2
    Bus = 16'h0041; LD_MAR = 1'b1;
    step();
    LD_MAR = 1'b0;
    Bus = 16'hCAFE; LD_MDR = 1'b1;
    step();
    LD_MDR = 1'b0;
    check("t3_mdr", MDR, 16'hCAFE);
    Mem_WE = 1'b0;
    step();
    check("t3_wp0_strobes", strobes, 5'b01000);
    check("t3_wp0_dq_oe", SRAM_DQ_oe, 1'b1);
    check("t3_wp0_dq_out", SRAM_DQ_out, 16'hCAFE);
    check("t3_wp0_ready", Mem_Ready, 1'b0);
    step();
    check("t3_wp1_we_n", SRAM_WE_N, 1'b0);
    check("t3_wp1_ready", Mem_Ready, 1'b0);
    step();
    check("t3_done_we_n", SRAM_WE_N, 1'b1);
    check("t3_done_dq_oe", SRAM_DQ_oe, 1'b1);
    check("t3_done_ready", Mem_Ready, 1'b1);
    step();
    check("t3_hold_ready", Mem_Ready, 1'b0);
    check("t3_hold_we_n", SRAM_WE_N, 1'b1);
    Mem_WE = 1'b1;
    step();
    check("t3_idle_dq_oe", SRAM_DQ_oe, 1'b0);
    check("t3_idle_strobes", strobes, 5'b11111);
    check("t3_hex", HEX_reg, 16'h0000);
    $display("T3 SRAM write 0041 <- CAFE");

    // 4: I/O write to HEX, then I/O read of Switches
    Bus = 16'hFFFF; LD_MAR = 1'b1;
    step();
    LD_MAR = 1'b0;
    Bus = 16'h00A5; LD_MDR = 1'b1;
    step();
    LD_MDR = 1'b0;
    Mem_WE = 1'b0;
    step();
    check("t4_wp0_we_n", SRAM_WE_N, 1'b1);
    check("t4_wp0_hex", HEX_reg, 16'h0000);
    step();
    check("t4_wp1_we_n", SRAM_WE_N, 1'b1);
    check("t4_wp1_hex", HEX_reg, 16'h0000);
    step();
    check("t4_done_hex", HEX_reg, 16'h00A5);
    check("t4_done_ready", Mem_Ready, 1'b1);
    Mem_WE = 1'b1;
    step();
    $display("T4a IO write HEX <- 00A5");
    Switches = 16'h5A5A; SRAM_DQ_in = 16'h1111;
    Mem_OE = 1'b0;
    step();
    step();
    step();
    check("t4_rd_ready", Mem_Ready, 1'b1);
    Mem_OE = 1'b1; LD_MDR = 1'b1; MIO_EN = 1'b1;
    step();
    LD_MDR = 1'b0; MIO_EN = 1'b0;
    check("t4_rd_mdr", MDR, 16'h5A5A);
    $display("T4b IO read switches -> 5A5A");

    // 5a: simultaneous OE and WE: write wins
    Bus = 16'h0050; LD_MAR = 1'b1;
    step();
    LD_MAR = 1'b0;
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    step();
    check("t5_both_we_n", SRAM_WE_N, 1'b0);
    check("t5_both_oe_n", SRAM_OE_N, 1'b1);
    step();
    check("t5_both1_oe_n", SRAM_OE_N, 1'b1);
    step();
    check("t5_both_ready", Mem_Ready, 1'b1);
    check("t5_both_done_oe_n", SRAM_OE_N, 1'b1);
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    step();
    check("t5_both_idle", strobes, 5'b11111);
    $display("T5a OE+WE together -> write only");

    // 5b: reset in RD_WAIT
    Mem_OE = 1'b0;
    step();
    check("t5_rw_oe_n", SRAM_OE_N, 1'b0);
    #1 Reset = 1'b1;
    #1;
    check("t5_rst_strobes", strobes, 5'b11111);
    check("t5_rst_mar", MAR, 16'h0000);
    check("t5_rst_ready", Mem_Ready, 1'b0);
    check("t5_rst_hex", HEX_reg, 16'h0000);
    Mem_OE = 1'b1;
    step();
    check("t5_rst_ready2", Mem_Ready, 1'b0);
    Reset = 1'b0;
    step();
    check("t5_post_ready", Mem_Ready, 1'b0);
    $display("T5b reset during RD_WAIT");

    // 6: full read of 2468 sets MDR/capture, then aborted read of DEAD
    Bus = 16'h0060; LD_MAR = 1'b1;
    step();
    LD_MAR = 1'b0;
    SRAM_DQ_in = 16'h2468; Mem_OE = 1'b0;
    step();
    step();
    step();
    Mem_OE = 1'b1; LD_MDR = 1'b1; MIO_EN = 1'b1;
    step();
    LD_MDR = 1'b0; MIO_EN = 1'b0;
    check("t6_pre_mdr", MDR, 16'h2468);
    SRAM_DQ_in = 16'hDEAD; Mem_OE = 1'b0;
    step();  // RD_WAIT, counter=1
    Mem_OE = 1'b1;
    step();  // abort
    check("t6_abort_ready", Mem_Ready, 1'b0);
    check("t6_abort_strobes", strobes, 5'b11111);
    step();
    check("t6_abort_ready2", Mem_Ready, 1'b0);
    check("t6_abort_strobes2", strobes, 5'b11111);
    LD_MDR = 1'b1; MIO_EN = 1'b1;
    step();
    LD_MDR = 1'b0; MIO_EN = 1'b0;
    check("t6_mdr", MDR, 16'h2468);
    $display("T6 aborted read, MDR kept 2468");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
